// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipeline control path: control-bundle bit
// positions, the bubble value and the EX operand forwarding encodings.
package ctrl_pkg;

    localparam int CTRL_WIDTH     = 11;
    localparam int REG_ADDR_WIDTH = 5;

    // Bit positions inside the control bundle (MSB..LSB order of the decoder)
    localparam int CTRL_DEST_SEL_HI = 10;
    localparam int CTRL_DEST_SEL_LO = 9;
    localparam int CTRL_JUMP_TYPE   = 8;
    localparam int CTRL_ITYPE       = 7;
    localparam int CTRL_BRANCH      = 6;
    localparam int CTRL_MEM_WEN     = 5;
    localparam int CTRL_ALU_OP      = 4;
    localparam int CTRL_ALU_SRC_A   = 3;
    localparam int CTRL_ALU_SRC_B   = 2;
    localparam int CTRL_REG_WEN     = 1;
    localparam int CTRL_MEM_READ    = 0;

    // All-zero bundle: no register write, no memory access
    localparam logic [CTRL_WIDTH-1:0] BUBBLE = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// Forwarding compare for one EX operand: youngest matching producer wins,
// loads sitting in MEM are skipped because the load-use stall covers them.
module fwd_unit
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_WIDTH
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  mem_reg_wen_i,
    input  logic                  mem_mem_read_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  wb_reg_wen_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    output logic [1:0]            fwd_o
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_wen_i && !mem_mem_read_i &&
                     (mem_rd_i != '0) && (mem_rd_i == rs_i);
    assign wb_hit  = wb_reg_wen_i && (wb_rd_i != '0) && (wb_rd_i == rs_i);

    always_comb begin
        fwd_o = FWD_RF;
        if (mem_hit) begin
            fwd_o = FWD_MEM;
        end else if (wb_hit) begin
            fwd_o = FWD_WB;
        end
    end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// Control-side pipeline: carries decoded bundles ID->EX->MEM->WB, inserts
// load-use bubbles, flushes on redirect and drives EX forwarding selects.
module ctrl_pipe_hazard
    import ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = REG_ADDR_WIDTH,
    parameter int CTRL_W     = CTRL_WIDTH
) (
    input  logic                  clk_I,
    input  logic                  rstN_I,
    input  logic [CTRL_W-1:0]     idCtrl_I,
    input  logic [REG_ADDR_W-1:0] idRs1_I,
    input  logic [REG_ADDR_W-1:0] idRs2_I,
    input  logic [REG_ADDR_W-1:0] idRd_I,
    input  logic                  redirect_I,
    input  logic                  memBusy_I,
    output logic [CTRL_W-1:0]     exCtrl_O,
    output logic [CTRL_W-1:0]     memCtrl_O,
    output logic [CTRL_W-1:0]     wbCtrl_O,
    output logic [REG_ADDR_W-1:0] exRd_O,
    output logic [REG_ADDR_W-1:0] memRd_O,
    output logic [REG_ADDR_W-1:0] wbRd_O,
    output logic [1:0]            fwdA_O,
    output logic [1:0]            fwdB_O,
    output logic                  stall_O,
    output logic                  flushIfId_O
);

    logic [CTRL_W-1:0]     ex_ctrl_q, ex_ctrl_d;
    logic [CTRL_W-1:0]     mem_ctrl_q, mem_ctrl_d;
    logic [CTRL_W-1:0]     wb_ctrl_q, wb_ctrl_d;
    logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
    logic                  load_use;
    logic                  stall_c;
    logic                  flush_c;

    // Both sources compared regardless of instruction format
    assign load_use = ex_ctrl_q[CTRL_MEM_READ] && (ex_rd_q != '0) &&
                      ((ex_rd_q == idRs1_I) || (ex_rd_q == idRs2_I));

    always_comb begin
        ex_ctrl_d  = ex_ctrl_q;
        mem_ctrl_d = mem_ctrl_q;
        wb_ctrl_d  = wb_ctrl_q;
        ex_rd_d    = ex_rd_q;
        mem_rd_d   = mem_rd_q;
        wb_rd_d    = wb_rd_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        stall_c    = 1'b0;
        flush_c    = 1'b0;

        if (memBusy_I) begin
            // Frozen pipe: a pending redirect stays in EX and re-presents later
            stall_c = 1'b1;
        end else begin
            mem_ctrl_d = ex_ctrl_q;
            mem_rd_d   = ex_rd_q;
            wb_ctrl_d  = mem_ctrl_q;
            wb_rd_d    = mem_rd_q;
            if (redirect_I || load_use) begin
                ex_ctrl_d = BUBBLE;
                ex_rd_d   = '0;
                ex_rs1_d  = '0;
                ex_rs2_d  = '0;
                flush_c   = redirect_I;
                stall_c   = !redirect_I;
            end else begin
                ex_ctrl_d = idCtrl_I;
                ex_rd_d   = idRd_I;
                ex_rs1_d  = idRs1_I;
                ex_rs2_d  = idRs2_I;
            end
        end
    end

    always_ff @(posedge clk_I or negedge rstN_I) begin
        if (!rstN_I) begin
            ex_ctrl_q  <= BUBBLE;
            mem_ctrl_q <= BUBBLE;
            wb_ctrl_q  <= BUBBLE;
            ex_rd_q    <= '0;
            mem_rd_q   <= '0;
            wb_rd_q    <= '0;
            ex_rs1_q   <= '0;
            ex_rs2_q   <= '0;
        end else begin
            ex_ctrl_q  <= ex_ctrl_d;
            mem_ctrl_q <= mem_ctrl_d;
            wb_ctrl_q  <= wb_ctrl_d;
            ex_rd_q    <= ex_rd_d;
            mem_rd_q   <= mem_rd_d;
            wb_rd_q    <= wb_rd_d;
            ex_rs1_q   <= ex_rs1_d;
            ex_rs2_q   <= ex_rs2_d;
        end
    end

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs_i          (ex_rs1_q),
        .mem_reg_wen_i (mem_ctrl_q[CTRL_REG_WEN]),
        .mem_mem_read_i(mem_ctrl_q[CTRL_MEM_READ]),
        .mem_rd_i      (mem_rd_q),
        .wb_reg_wen_i  (wb_ctrl_q[CTRL_REG_WEN]),
        .wb_rd_i       (wb_rd_q),
        .fwd_o         (fwdA_O)
    );

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs_i          (ex_rs2_q),
        .mem_reg_wen_i (mem_ctrl_q[CTRL_REG_WEN]),
        .mem_mem_read_i(mem_ctrl_q[CTRL_MEM_READ]),
        .mem_rd_i      (mem_rd_q),
        .wb_reg_wen_i  (wb_ctrl_q[CTRL_REG_WEN]),
        .wb_rd_i       (wb_rd_q),
        .fwd_o         (fwdB_O)
    );

    assign exCtrl_O    = ex_ctrl_q;
    assign memCtrl_O   = mem_ctrl_q;
    assign wbCtrl_O    = wb_ctrl_q;
    assign exRd_O      = ex_rd_q;
    assign memRd_O     = mem_rd_q;
    assign wbRd_O      = wb_rd_q;
    assign stall_O     = stall_c;
    assign flushIfId_O = flush_c;

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Bench for ctrl_pipe_hazard: a reference pipeline model pushes expected
// stage contents per driven cycle; they are popped after the edge and compared.
module tb_ctrl_pipe_hazard;

    localparam logic [10:0] NOP  = 11'd0;
    localparam logic [10:0] LOAD = 11'b000_1000_0111; // IType|aluSrcB|regWEn|memReadEn
    localparam logic [10:0] ADD  = 11'b010_0001_0010; // destSel=01|aluOp|regWEn
    localparam logic [10:0] SUB  = 11'b000_0001_1010; // aluOp|aluSrcA|regWEn
    localparam logic [10:0] BEQ  = 11'b000_0100_0000; // branch, no write

    logic        clk;
    logic        rst_n;
    logic [10:0] id_ctrl;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        redirect, mem_busy;
    logic [10:0] ex_ctrl, mem_ctrl, wb_ctrl;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall, flush;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [10:0] ex, mem, wb;
        logic [4:0]  exrd, memrd, wbrd;
        logic [1:0]  fa, fb;
    } exp_t;

    exp_t sb[$];

    // reference model state: index 0=EX, 1=MEM, 2=WB
    logic [10:0] m_ctrl [3];
    logic [4:0]  m_rd   [3];
    logic [4:0]  m_rs1, m_rs2;

    ctrl_pipe_hazard dut (
        .clk_I      (clk),
        .rstN_I     (rst_n),
        .idCtrl_I   (id_ctrl),
        .idRs1_I    (id_rs1),
        .idRs2_I    (id_rs2),
        .idRd_I     (id_rd),
        .redirect_I (redirect),
        .memBusy_I  (mem_busy),
        .exCtrl_O   (ex_ctrl),
        .memCtrl_O  (mem_ctrl),
        .wbCtrl_O   (wb_ctrl),
        .exRd_O     (ex_rd),
        .memRd_O    (mem_rd),
        .wbRd_O     (wb_rd),
        .fwdA_O     (fwd_a),
        .fwdB_O     (fwd_b),
        .stall_O    (stall),
        .flushIfId_O(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [1:0] model_fwd(input logic [4:0] rs);
        if (m_ctrl[1][1] && !m_ctrl[1][0] && m_rd[1] != 5'd0 && m_rd[1] == rs) return 2'b10;
        if (m_ctrl[2][1] && m_rd[2] != 5'd0 && m_rd[2] == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_ctrl[i] = '0;
            m_rd[i]   = '0;
        end
        m_rs1 = '0;
        m_rs2 = '0;
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.ex = m_ctrl[0]; e.mem = m_ctrl[1]; e.wb = m_ctrl[2];
        e.exrd = m_rd[0]; e.memrd = m_rd[1]; e.wbrd = m_rd[2];
        e.fa = model_fwd(m_rs1);
        e.fb = model_fwd(m_rs2);
        return e;
    endfunction

    task automatic cmp_outputs(input exp_t e);
        chk("ex_ctrl", ex_ctrl, e.ex);
        chk("mem_ctrl", mem_ctrl, e.mem);
        chk("wb_ctrl", wb_ctrl, e.wb);
        chk("ex_rd", ex_rd, e.exrd);
        chk("mem_rd", mem_rd, e.memrd);
        chk("wb_rd", wb_rd, e.wbrd);
        chk("fwd_a", fwd_a, e.fa);
        chk("fwd_b", fwd_b, e.fb);
    endtask

    // One pipeline cycle: drive ID, check comb stall/flush, advance model, check stages
    task automatic step(input logic [10:0] c, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic rdr, input logic busy);
        logic lu;
        exp_t e;
        @(negedge clk);
        id_ctrl = c; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        redirect = rdr; mem_busy = busy;
        #1;
        lu = m_ctrl[0][0] && m_rd[0] != 5'd0 && (m_rd[0] == r1 || m_rd[0] == r2);
        chk("stall", stall, busy || (!rdr && lu));
        chk("flush", flush, !busy && rdr);
        if (!busy) begin
            m_ctrl[2] = m_ctrl[1]; m_rd[2] = m_rd[1];
            m_ctrl[1] = m_ctrl[0]; m_rd[1] = m_rd[0];
            if (rdr || lu) begin
                m_ctrl[0] = '0; m_rd[0] = '0; m_rs1 = '0; m_rs2 = '0;
            end else begin
                m_ctrl[0] = c; m_rd[0] = rd; m_rs1 = r1; m_rs2 = r2;
            end
        end
        sb.push_back(model_snapshot());
        @(posedge clk);
        #1;
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp_outputs(e);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        id_ctrl = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        redirect = 1'b0; mem_busy = 1'b0;
        model_clear();
        #1;
        cmp_outputs(model_snapshot());
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // load-use: one bubble, then consumer forwards from MEM/WB
        step(LOAD, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0);
        step(ADD,  5'd5, 5'd2, 5'd6, 1'b0, 1'b0);
        step(ADD,  5'd5, 5'd2, 5'd6, 1'b0, 1'b0);
        step(NOP,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        // forwarding priority: MEM over WB, then MEM rd=x0 falls through to WB
        step(SUB,  5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        step(ADD,  5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        step(ADD,  5'd4, 5'd3, 5'd8, 1'b0, 1'b0);
        step(SUB,  5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        step(ADD,  5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        step(ADD,  5'd4, 5'd3, 5'd8, 1'b0, 1'b0);

        // redirect wins over a simultaneous load-use
        step(LOAD, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0);
        step(ADD,  5'd9, 5'd7, 5'd6, 1'b1, 1'b0);
        step(NOP,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        // memBusy freezes the pipe for three cycles with redirect held
        step(ADD,  5'd1, 5'd2, 5'd10, 1'b0, 1'b0);
        step(SUB,  5'd3, 5'd4, 5'd11, 1'b0, 1'b0);
        step(BEQ,  5'd10, 5'd11, 5'd0, 1'b0, 1'b0);
        repeat (3) step(ADD, 5'd10, 5'd11, 5'd12, 1'b1, 1'b1);
        step(ADD,  5'd10, 5'd11, 5'd12, 1'b1, 1'b0);

        // x0 is never a hazard nor a forwarding source
        step(LOAD, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        step(ADD,  5'd0, 5'd0, 5'd13, 1'b0, 1'b0);
        step(NOP,  5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        // random mix
        for (int i = 0; i < 40; i++) begin
            step(11'($urandom_range(0, 2047)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
        end

        // mid-stream asynchronous reset with a full pipe
        step(ADD, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
        step(SUB, 5'd3, 5'd2, 5'd4, 1'b0, 1'b0);
        step(ADD, 5'd4, 5'd3, 5'd5, 1'b0, 1'b0);
        @(negedge clk);
        id_ctrl = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        redirect = 1'b0; mem_busy = 1'b0;
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        cmp_outputs(model_snapshot());
        chk("arst_stall", stall, 0);
        chk("arst_flush", flush, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_hazard.md
Name: ctrl_pipe_hazard

Overview:
- Consumer end of the control decoder interface. Takes the decoded control bundle in ID, together with the ID register addresses.
- Carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and inserts bubbles. Flushes on redirect.
- Generates forwarding selects for the EX-stage ALU operand muxes.
- Sits between the decoder/register-file stage and the datapath pipeline registers. Drives PC/IF-ID hold and flush.

Parameters:
- REG_ADDR_W, 5, register address width.
- CTRL_W, 11, control bundle width, in this bit order MSB..LSB: destRegWriteSel[1:0], jumpType, IType, branch, memWriteEn, aluOp, aluSrcA, aluSrcB, regWEn, memReadEn.

Ports:
- clk_I  in  1  clock, rising edge.
- rstN_I  in  1  asynchronous active-low reset.
- idCtrl_I  in  CTRL_W  decoded control bundle for the instruction in ID.
- idRs1_I  in  REG_ADDR_W  ID source register 1.
- idRs2_I  in  REG_ADDR_W  ID source register 2.
- idRd_I  in  REG_ADDR_W  ID destination register.
- redirect_I  in  1  branch taken or jump resolved in EX this cycle.
- memBusy_I  in  1  data memory not ready; freezes the whole pipe.
- exCtrl_O  out  CTRL_W  ID/EX control register.
- memCtrl_O  out  CTRL_W  EX/MEM control register.
- wbCtrl_O  out  CTRL_W  MEM/WB control register.
- exRd_O, memRd_O, wbRd_O  out  REG_ADDR_W  destination register per stage.
- fwdA_O, fwdB_O  out  2  EX operand select: 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
- stall_O  out  1  hold PC and IF/ID.
- flushIfId_O  out  1  replace IF/ID with a NOP.

Behaviour:
- Reset: all stage control registers, rd registers and the stored EX rs1/rs2 clear to 0 (bubble). fwdA_O/fwdB_O=00, stall_O=0, flushIfId_O=0. Reset is honoured mid-operation with no pending state retained.
- Bubble: all-zero bundle, rd=0. It must never write a register or memory.
- Stage registers hold ctrl, rd, and in EX also rs1/rs2. On an un-stalled edge each stage loads its predecessor.
- Load-use hazard: loadUse = exCtrl.memReadEn & (exRd != 0) & (exRd == idRs1_I | exRd == idRs2_I).
  - The check is conservative: both sources are compared regardless of instruction type.
- Priority, evaluated each cycle:
  1. memBusy_I=1: every register holds its value, stall_O=1, flushIfId_O=0, redirect_I ignored. The EX stage is frozen, so the redirect re-presents itself after the freeze.
  2. redirect_I=1: ID/EX loads a bubble, EX/MEM and MEM/WB advance, flushIfId_O=1, stall_O=0. Any simultaneous load-use hazard is discarded.
  3. loadUse=1: ID/EX loads a bubble, later stages advance, stall_O=1, flushIfId_O=0. Exactly one bubble per load-use; the next cycle's check then sees a bubble in EX.
  4. Otherwise all stages advance.
- Forwarding, combinational from the registered state (fwdB mirrors fwdA using exRs2):
  - fwdA=10 if memCtrl.regWEn & memRd!=0 & memRd==exRs1.
  - Else fwdA=01 if wbCtrl.regWEn & wbRd!=0 & wbRd==exRs1.
  - Else fwdA=00.
  - EX/MEM has priority over MEM/WB (youngest producer wins).
  - Loads in MEM are not forwarded from EX/MEM: they are already covered by the stall.
- stall_O and flushIfId_O are combinational in the same cycle as the condition. They are never both 1.
- No latency beyond one clock per stage: a bundle presented in ID at edge n appears on exCtrl_O after n, memCtrl_O after n+1, wbCtrl_O after n+2, absent stalls.

Decomposition:
- Shared package ctrl_pkg holds: the CTRL_W bit-index constants, the bubble constant, and the FWD_RF/FWD_MEM/FWD_WB encodings.
- One natural sub-module: fwd_unit, the combinational forwarding compare instantiated for operands A and B.

Test Plan:
- Reset mid-stream: pipe holding three valid bundles, rstN_I low -> all outputs 0 immediately (asynchronous), pipe remains empty after release.
- Load-use: load x5 in EX, add rs1=x5 in ID -> stall_O=1 for exactly 1 cycle, exCtrl_O=0 next cycle, add enters EX one cycle later with fwdA=01.
- Forward priority: add x3 in MEM, sub x3 in WB, EX uses rs2=x3 -> fwdB=10; with MEM rd=x0 and WB rd=x3 -> fwdB=01.
- Redirect plus load-use same cycle: redirect_I=1 with loadUse=1 -> flushIfId_O=1, stall_O=0, exCtrl_O bubble next cycle.
- memBusy for 3 cycles with redirect_I held -> all stage outputs unchanged for 3 cycles, stall_O=1. Redirect flush occurs on the first cycle after memBusy_I drops.
- x0 handling: load x0 in EX, ID rs1=x0 -> no stall, fwdA=00.
